// File: rtl/dcd_offset_pkg.sv
`default_nettype none
//==============================================================================
// Module      : dcd_offset_pkg
// Description : Shared constants and state encoding for the DCD offset
//               transmitter (sync words, idle word, row state machine).
// Revision    : 1.0 - initial release
//==============================================================================
package dcd_offset_pkg;

   // Words driven on the offset lane outside of row data
   localparam logic [7:0] SYNC_OK   = 8'hA5;
   localparam logic [7:0] SYNC_ERR  = 8'h5A;
   localparam logic [7:0] IDLE_WORD = 8'h00;

   // Row transmission state machine
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/offset_fifo.sv
`default_nettype none
//==============================================================================
// Module      : offset_fifo
// Description : Synchronous show-ahead FIFO with registered occupancy count.
//               The head entry is always visible on data_o; pop_i consumes it.
// Revision    : 1.0 - initial release
//==============================================================================
module offset_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     ready_o
);

   localparam int             PW      = $clog2(DEPTH);
   localparam logic [PW:0]    DEPTH_C = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW:0]      count_q;
   logic             push_ok;
   logic             pop_ok;

   // Ready comes only from the registered count, held low while in reset
   assign ready_o = !rst_i && (count_q < DEPTH_C);
   assign push_ok = push_i && ready_o;
   // Guard against popping an empty buffer even though the FSM never asks
   assign pop_ok  = pop_i && (count_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Storage array: written on accepted pushes, no reset needed
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/dcd_offset_tx.sv
`default_nettype none
//==============================================================================
// Module      : dcd_offset_tx
// Description : Buffers offset bytes and, on request, sends one row as a sync
//               word followed by ROW_WORDS bytes on the 2-pin offset lane word.
// Revision    : 1.0 - initial release
//==============================================================================
module dcd_offset_tx
   import dcd_offset_pkg::*;
#(
   parameter int ROW_WORDS  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          CLK_80,
   input  logic                          RESET,
   input  logic [7:0]                    DATA_IN,
   input  logic                          DATA_VALID,
   output logic                          DATA_READY,
   input  logic                          ROW_START,
   input  logic                          ENABLE,
   input  logic                          CLEAR_FLAGS,
   output logic [7:0]                    DI_PAR,
   output logic                          BUSY,
   output logic                          UNDERFLOW,
   output logic                          ROW_OVERRUN,
   output logic [$clog2(FIFO_DEPTH):0]   FILL
);

   localparam int              CW          = $clog2(FIFO_DEPTH) + 1;
   localparam int              WCW         = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
   localparam logic [CW-1:0]   ROW_WORDS_C = CW'(ROW_WORDS);
   localparam logic [WCW-1:0]  LAST_WORD   = WCW'(ROW_WORDS - 1);

   state_e           state_q, state_d;
   logic             good_q, good_d;
   logic [WCW-1:0]   cnt_q, cnt_d;
   logic [7:0]       dout_q, dout_d;
   logic             underflow_q, underflow_d;
   logic             overrun_q, overrun_d;
   logic             start_ok;
   logic             pop;
   logic [7:0]       fifo_head;
   logic [CW-1:0]    fifo_count;

   offset_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (CLK_80),
      .rst_i   (RESET),
      .push_i  (DATA_VALID),
      .data_i  (DATA_IN),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .count_o (fifo_count),
      .ready_o (DATA_READY)
   );

   assign start_ok    = ROW_START && ENABLE;
   assign BUSY        = (state_q != ST_IDLE);
   assign DI_PAR      = dout_q;
   assign UNDERFLOW   = underflow_q;
   assign ROW_OVERRUN = overrun_q;
   assign FILL        = fifo_count;

   // Next state, output word and pop request; the output word follows the
   // next state so it lines up with BUSY one edge after the request
   always_comb begin
      state_d     = state_q;
      good_d      = good_q;
      cnt_d       = cnt_q;
      dout_d      = IDLE_WORD;
      pop         = 1'b0;
      underflow_d = underflow_q;
      overrun_d   = overrun_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_SYNC;
               good_d  = (fifo_count >= ROW_WORDS_C);
            end
         end
         ST_SYNC: begin
            state_d = ST_DATA;
            cnt_d   = '0;
         end
         ST_DATA: begin
            if (cnt_q == LAST_WORD) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + WCW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      unique case (state_d)
         ST_SYNC: dout_d = good_d ? SYNC_OK : SYNC_ERR;
         ST_DATA: begin
            if (good_d) begin
               pop    = 1'b1;
               dout_d = fifo_head;
            end
         end
         default: dout_d = IDLE_WORD;
      endcase

      // A set event wins over a simultaneous clear
      if (state_q == ST_IDLE && start_ok && !good_d) begin
         underflow_d = 1'b1;
      end else if (CLEAR_FLAGS) begin
         underflow_d = 1'b0;
      end

      if (state_q != ST_IDLE && start_ok) begin
         overrun_d = 1'b1;
      end else if (CLEAR_FLAGS) begin
         overrun_d = 1'b0;
      end
   end

   // State, row decision, word counter, output word and sticky flags
   always_ff @(posedge CLK_80 or posedge RESET) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         good_q      <= 1'b0;
         cnt_q       <= '0;
         dout_q      <= IDLE_WORD;
         underflow_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         good_q      <= good_d;
         cnt_q       <= cnt_d;
         dout_q      <= dout_d;
         underflow_q <= underflow_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dcd_offset_tx.sv
`default_nettype none
//==============================================================================
// Module      : tb_dcd_offset_tx
// Description : Scoreboard bench for dcd_offset_tx with a queue-based row model
//               and a 2-pin receive-path reconstruction of DI_PAR.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_dcd_offset_tx;
   import dcd_offset_pkg::*;

   localparam int RW    = 8;
   localparam int DEPTH = 16;

   logic       CLK_80 = 1'b0;
   logic       RESET  = 1'b1;
   logic [7:0] DATA_IN = 8'h00;
   logic       DATA_VALID = 1'b0;
   logic       ROW_START = 1'b0;
   logic       ENABLE = 1'b0;
   logic       CLEAR_FLAGS = 1'b0;
   logic       DATA_READY;
   logic [7:0] DI_PAR;
   logic       BUSY;
   logic       UNDERFLOW;
   logic       ROW_OVERRUN;
   logic [4:0] FILL;

   dcd_offset_tx #(.ROW_WORDS(RW), .FIFO_DEPTH(DEPTH)) dut (
      .CLK_80      (CLK_80),
      .RESET       (RESET),
      .DATA_IN     (DATA_IN),
      .DATA_VALID  (DATA_VALID),
      .DATA_READY  (DATA_READY),
      .ROW_START   (ROW_START),
      .ENABLE      (ENABLE),
      .CLEAR_FLAGS (CLEAR_FLAGS),
      .DI_PAR      (DI_PAR),
      .BUSY        (BUSY),
      .UNDERFLOW   (UNDERFLOW),
      .ROW_OVERRUN (ROW_OVERRUN),
      .FILL        (FILL)
   );

   always #5 CLK_80 = ~CLK_80;

   typedef struct {
      int fill;
      bit ready;
      bit busy;
      bit uf;
      bit ov;
   } status_t;

   status_t    st_q[$];
   logic [7:0] dat_q[$];

   // Reference model: bytes not yet claimed by a row, bytes claimed but still
   // inside the DUT buffer, cycles of busy left, and the sticky flags
   logic [7:0] mq[$];
   int         pending;
   int         busy_cnt;
   bit         m_good;
   bit         m_uf;
   bit         m_ov;

   int total;
   int bad;

   task automatic check(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model across one rising edge using the inputs now applied
   task automatic model_edge();
      int fill_now  = mq.size() + pending;
      bit acc       = DATA_VALID && (fill_now < DEPTH);
      bit start     = ROW_START && ENABLE;
      bit start_row = start && (busy_cnt == 0);
      bit good      = fill_now >= RW;
      if (busy_cnt >= 2 && m_good) pending--;
      if (busy_cnt > 0) busy_cnt--;
      if (start_row) begin
         m_good   = good;
         busy_cnt = RW + 1;
         dat_q.push_back(good ? SYNC_OK : SYNC_ERR);
         for (int k = 0; k < RW; k++) begin
            if (good) begin
               dat_q.push_back(mq.pop_front());
               pending++;
            end else begin
               dat_q.push_back(IDLE_WORD);
            end
         end
      end
      if (acc) mq.push_back(DATA_IN);
      if (start_row && !good) m_uf = 1'b1;
      else if (CLEAR_FLAGS)   m_uf = 1'b0;
      if (start && !start_row) m_ov = 1'b1;
      else if (CLEAR_FLAGS)    m_ov = 1'b0;
      st_q.push_back('{fill: mq.size() + pending,
                       ready: (mq.size() + pending) < DEPTH,
                       busy: busy_cnt > 0, uf: m_uf, ov: m_ov});
   endtask

   task automatic drive(bit v, logic [7:0] d, bit s, bit en, bit clr);
      @(negedge CLK_80);
      DATA_VALID  = v;
      DATA_IN     = d;
      ROW_START   = s;
      ENABLE      = en;
      CLEAR_FLAGS = clr;
      model_edge();
   endtask

   task automatic idle(int n);
      repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic push_n(int n);
      repeat (n) drive(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge CLK_80);
      RESET       = 1'b1;
      DATA_VALID  = 1'b0;
      ROW_START   = 1'b0;
      CLEAR_FLAGS = 1'b0;
      mq.delete();
      dat_q.delete();
      st_q.delete();
      pending  = 0;
      busy_cnt = 0;
      m_good   = 1'b0;
      m_uf     = 1'b0;
      m_ov     = 1'b0;
      #1;
      check("rst_di_par", DI_PAR, 0);
      check("rst_fill", FILL, 0);
      check("rst_busy", BUSY, 0);
      check("rst_ready", DATA_READY, 0);
      check("rst_underflow", UNDERFLOW, 0);
      check("rst_overrun", ROW_OVERRUN, 0);
      repeat (2) @(posedge CLK_80);
      @(negedge CLK_80);
      RESET = 1'b0;
      #1;
      check("rel_ready", DATA_READY, 1);
      model_edge();
   endtask

   // Monitor: compares every cycle's status and, while BUSY, each lane word,
   // also passing the word through a 1:4 receive model of the two pins
   initial begin
      status_t    e;
      logic [7:0] ex;
      logic [7:0] rx;
      logic [1:0] sym[$];
      logic [1:0] s;
      forever begin
         @(posedge CLK_80);
         #1;
         if (!RESET) begin
            if (st_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL status_queue: got empty expected entry at %0t", $time);
            end else begin
               e = st_q.pop_front();
               check("fill", FILL, e.fill);
               check("ready", DATA_READY, e.ready);
               check("busy", BUSY, e.busy);
               check("underflow", UNDERFLOW, e.uf);
               check("overrun", ROW_OVERRUN, e.ov);
            end
            if (BUSY) begin
               if (dat_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL data_queue: got word %0h expected none at %0t", DI_PAR, $time);
               end else begin
                  ex = dat_q.pop_front();
                  check("di_par", DI_PAR, ex);
                  for (int t = 0; t < 4; t++) sym.push_back({DI_PAR[4+t], DI_PAR[t]});
                  rx = 8'h00;
                  for (int t = 0; t < 4; t++) begin
                     s = sym.pop_front();
                     rx[t]   = s[0];
                     rx[4+t] = s[1];
                  end
                  check("rx_path", rx, ex);
               end
            end else begin
               check("di_par_idle", DI_PAR, 0);
            end
         end
      end
   end

   initial begin
      total    = 0;
      bad      = 0;
      pending  = 0;
      busy_cnt = 0;
      do_reset();

      // Known row 01..08
      for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
      idle(2);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(12);

      // Short row: five bytes only
      push_n(5);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(12);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      idle(2);

      // Overfill with DATA_VALID held, then start a row while still pushing
      push_n(20);
      drive(1'b1, 8'($urandom), 1'b1, 1'b1, 1'b0);
      push_n(14);
      idle(3);
      repeat (2) begin
         drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         idle(12);
      end

      // Second request three cycles into a row
      push_n(8);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(2);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(12);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      idle(2);

      // Request with ENABLE low, then a row with ENABLE dropped mid-row
      push_n(8);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      repeat (6) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      idle(6);

      // Reset four cycles into a good row, then refill and send again
      push_n(8);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(3);
      do_reset();
      push_n(8);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(12);

      // Random traffic
      repeat (600) begin
         drive($urandom_range(0, 3) != 0, 8'($urandom),
               $urandom_range(0, 11) == 0, $urandom_range(0, 7) != 0,
               $urandom_range(0, 15) == 0);
      end
      idle(15);

      @(posedge CLK_80);
      #2;
      check("data_queue_drained", dat_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
